// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the three command sources, the UART transmitter
// and the arbiter that shares it.
interface uart_tx_arbiter_if;
    logic [2:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [7:0] req_data2;
    logic [2:0] req_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_timeout;

    // Requesters and transmitter side
    modport master (
        output req_valid, req_data0, req_data1, req_data2, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, busy, err_timeout
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data0, req_data1, req_data2, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the manual panel,
// script engine and status poller, with start/busy handshake, ack timeout and
// a minimum idle gap between frames.
module uart_tx_arbiter #(
    parameter int unsigned GAP_CYCLES  = 1000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus
);

    localparam int unsigned CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CW      = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    last;
    logic [7:0]    tx_data_q;
    logic          tx_start_q;
    logic [2:0]    req_ready_q;
    logic          busy_q;
    logic          err_q;

    logic [1:0]    c0, c1, c2;
    logic          win_valid;
    logic [1:0]    win_id;
    logic [7:0]    win_data;

    // Round-robin pick: search starts at the requester after the last winner
    always_comb begin
        c0 = 2'd0;
        c1 = 2'd1;
        c2 = 2'd2;
        case (last)
            2'd0: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase

        win_valid = 1'b1;
        win_id    = last;
        if (bus.req_valid[c0])
            win_id = c0;
        else if (bus.req_valid[c1])
            win_id = c1;
        else if (bus.req_valid[c2])
            win_id = c2;
        else
            win_valid = 1'b0;

        case (win_id)
            2'd0:    win_data = bus.req_data0;
            2'd1:    win_data = bus.req_data1;
            default: win_data = bus.req_data2;
        endcase
    end

    // Grant / handshake / gap state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 2'd2;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        tx_data_q   <= win_data;
                        tx_start_q  <= 1'b1;
                        req_ready_q <= 3'b001 << win_id;
                        last        <= win_id;
                        cnt         <= '0;
                        busy_q      <= 1'b1;
                        state       <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // An ack on the final cycle takes priority over the timeout
                    if (bus.tx_busy) begin
                        err_q <= 1'b0;
                        state <= WAIT_DONE;
                    end else if (cnt == ACK_LAST) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.req_ready   = req_ready_q;
    assign bus.grant_id    = last;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;

endmodule
